carry_look_ahead_adder: RTL and testbench

CARRY_LOOK_AHEAD_ADDER -- requirements
Module: carry_look_ahead_adder

---
 rtl/carry_look_ahead_adder.sv | 131 +++++++++++++
 tb/tb_carry_look_ahead_adder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/carry_look_ahead_adder.sv
// Two-level carry-lookahead adder: 4-bit groups with a group-level lookahead
// stage, and registered sum, carry-out and signed-overflow outputs.
module carry_look_ahead_adder #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         C_in,
   input  logic         in_valid,
   output logic [N-1:0] S,
   output logic         C_out,
   output logic         V,
   output logic         out_valid
);

   localparam int GW = 4;
   localparam int NG = (N + GW - 1) / GW;
   localparam int NP = NG * GW;

   logic [N-1:0]  g, p, sum;
   logic [NP-1:0] gx, px;
   logic [NG-1:0] gg, gp;
   logic [NG:0]   gc;
   logic [NP:0]   cx;
   logic [N:0]    c;
   logic          ovf;

   assign g = A & B;
   assign p = A ^ B;

   // A partial top group is padded with g=0/p=1 bits, which pass the carry
   // through unchanged, so every group can use the full 4-bit equations.
   assign gx = NP'(g);
   assign px = ~(NP'(~p));

   // First level: group generate and group propagate.
   // NOTE: every variable written in this always_comb gets a value before any
   // path can read it, so no latch can be inferred.
   always_comb begin
      logic term;
      gg   = '0;
      gp   = '1;
      term = 1'b0;
      for (int k = 0; k < NG; k++) begin
         for (int j = 0; j < GW; j++) begin
            term = gx[k*GW+j];
            for (int m = j + 1; m < GW; m++) begin
               term = term & px[k*GW+m];
            end
            gg[k] = gg[k] | term;
            gp[k] = gp[k] & px[k*GW+j];
         end
      end
   end

   // Second level: each group carry-in is a flat sum-of-products of C_in, GG and GP.
   always_comb begin
      logic acc;
      logic term;
      gc    = '0;
      gc[0] = C_in;
      acc   = 1'b0;
      term  = 1'b0;
      for (int k = 0; k < NG; k++) begin
         acc = C_in;
         for (int l = 0; l <= k; l++) begin
            acc = acc & gp[l];
         end
         for (int m = 0; m <= k; m++) begin
            term = gg[m];
            for (int l = m + 1; l <= k; l++) begin
               term = term & gp[l];
            end
            acc = acc | term;
         end
         gc[k+1] = acc;
      end
   end

   // Bit carries inside each group, expanded from that group's carry-in.
   always_comb begin
      logic acc;
      logic term;
      cx   = '0;
      acc  = 1'b0;
      term = 1'b0;
      for (int k = 0; k < NG; k++) begin
         cx[k*GW] = gc[k];
         for (int j = 1; j < GW; j++) begin
            acc = gc[k];
            for (int l = 0; l < j; l++) begin
               acc = acc & px[k*GW+l];
            end
            for (int m = 0; m < j; m++) begin
               term = gx[k*GW+m];
               for (int l = m + 1; l < j; l++) begin
                  term = term & px[k*GW+l];
               end
               acc = acc | term;
            end
            cx[k*GW+j] = acc;
         end
      end
      cx[NP] = gc[NG];
   end

   assign c   = cx[N:0];
   assign sum = p ^ c[N-1:0];
   assign ovf = c[N] ^ c[N-1];

   // NOTE: sequential state uses non-blocking assignments only; the async
   // clear sits in the sensitivity list so it acts without a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         S         <= '0;
         C_out     <= 1'b0;
         V         <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            S     <= sum;
            C_out <= c[N];
            V     <= ovf;
         end
      end
   end

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// Directed-vector and random bench for carry_look_ahead_adder; one N=8 instance
// carries the directed checks, five more widths share the random stimulus.
module tb_carry_look_ahead_adder;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] s;
      logic       co;
      logic       v;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [63:0] a_full;
   logic [63:0] b_full;
   logic        c_in;
   logic        in_valid;

   logic [7:0]  s8;
   logic        c8, v8, ov8;
   logic [0:0]  s1;
   logic        c1, v1, ov1;
   logic [3:0]  s4;
   logic        c4, v4, ov4;
   logic [6:0]  s7;
   logic        c7, v7, ov7;
   logic [15:0] s16;
   logic        c16, v16, ov16;
   logic [31:0] s32;
   logic        c32, v32, ov32;

   int n_checks = 0;
   int n_fails  = 0;

   carry_look_ahead_adder #(.N(8)) dut (
      .clk(clk), .rst_n(rst_n), .A(a_full[7:0]), .B(b_full[7:0]), .C_in(c_in),
      .in_valid(in_valid), .S(s8), .C_out(c8), .V(v8), .out_valid(ov8));
   carry_look_ahead_adder #(.N(1)) dut_n1 (
      .clk(clk), .rst_n(rst_n), .A(a_full[0:0]), .B(b_full[0:0]), .C_in(c_in),
      .in_valid(in_valid), .S(s1), .C_out(c1), .V(v1), .out_valid(ov1));
   carry_look_ahead_adder #(.N(4)) dut_n4 (
      .clk(clk), .rst_n(rst_n), .A(a_full[3:0]), .B(b_full[3:0]), .C_in(c_in),
      .in_valid(in_valid), .S(s4), .C_out(c4), .V(v4), .out_valid(ov4));
   carry_look_ahead_adder #(.N(7)) dut_n7 (
      .clk(clk), .rst_n(rst_n), .A(a_full[6:0]), .B(b_full[6:0]), .C_in(c_in),
      .in_valid(in_valid), .S(s7), .C_out(c7), .V(v7), .out_valid(ov7));
   carry_look_ahead_adder #(.N(16)) dut_n16 (
      .clk(clk), .rst_n(rst_n), .A(a_full[15:0]), .B(b_full[15:0]), .C_in(c_in),
      .in_valid(in_valid), .S(s16), .C_out(c16), .V(v16), .out_valid(ov16));
   carry_look_ahead_adder #(.N(32)) dut_n32 (
      .clk(clk), .rst_n(rst_n), .A(a_full[31:0]), .B(b_full[31:0]), .C_in(c_in),
      .in_valid(in_valid), .S(s32), .C_out(c32), .V(v32), .out_valid(ov32));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer addition on masked operands; overflow from operand/result signs.
   task automatic check_rand(input string nm, input int n, input logic [63:0] s_act,
                             input logic c_act, input logic v_act, input logic ov_act);
      logic [63:0] mask;
      logic [64:0] e;
      logic [64:0] act;
      logic        ev;
      mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
      e    = {1'b0, a_full & mask} + {1'b0, b_full & mask} + 65'(c_in);
      ev   = (a_full[n-1] == b_full[n-1]) && (e[n-1] != a_full[n-1]);
      act    = 65'(s_act);
      act[n] = c_act;
      check({nm, "_sum"}, act, e);
      check({nm, "_v"}, 65'(v_act), 65'(ev));
      check({nm, "_valid"}, 65'(ov_act), 65'd1);
   endtask

   task automatic check_out8(input string nm, input logic [7:0] es, input logic eco,
                             input logic ev, input logic eov);
      check({nm, "_s"}, 65'(s8), 65'(es));
      check({nm, "_cout"}, 65'(c8), 65'(eco));
      check({nm, "_v"}, 65'(v8), 65'(ev));
      check({nm, "_valid"}, 65'(ov8), 65'(eov));
   endtask

   initial begin
      vec_t       vecs [9];
      logic [7:0] hold_s;
      logic       hold_c, hold_v;
      logic [8:0] e9;

      vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
      vecs[1] = '{8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[2] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};
      vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[7] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[8] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};

      // Reset held across an edge with in_valid high: outputs must stay cleared.
      rst_n    = 1'b0;
      a_full   = 64'h0F;
      b_full   = 64'h01;
      c_in     = 1'b1;
      in_valid = 1'b1;
      #12;
      check_out8("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;

      // Directed table, applied back-to-back with in_valid held high.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         a_full   = 64'(vecs[i].a);
         b_full   = 64'(vecs[i].b);
         c_in     = vecs[i].cin;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         check_out8($sformatf("vec%0d", i), vecs[i].s, vecs[i].co, vecs[i].v, 1'b1);
      end

      // in_valid low: result holds, out_valid drops.
      @(negedge clk);
      a_full   = 64'h12;
      b_full   = 64'h34;
      c_in     = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_out8("hold", 8'hFF, 1'b0, 1'b1, 1'b0);

      // Mid-stream reset between edges clears outputs immediately.
      @(negedge clk);
      a_full   = 64'h0F;
      b_full   = 64'h01;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check_out8("pre_rst", 8'h10, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      a_full = 64'h20;
      b_full = 64'h01;
      #2;
      rst_n = 1'b0;
      #1;
      check_out8("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_out8("rst_ignores_valid", 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_out8("post_rst_idle", 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check_out8("post_rst_first", 8'h21, 1'b0, 1'b0, 1'b1);
      hold_s = 8'h21;
      hold_c = 1'b0;
      hold_v = 1'b0;

      // Random stream across all widths with occasional idle cycles.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         a_full   = {$urandom, $urandom};
         b_full   = {$urandom, $urandom};
         c_in     = 1'($urandom_range(0, 1));
         in_valid = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
         if (in_valid) begin
            check_rand("n1", 1, 64'(s1), c1, v1, ov1);
            check_rand("n4", 4, 64'(s4), c4, v4, ov4);
            check_rand("n7", 7, 64'(s7), c7, v7, ov7);
            check_rand("n8", 8, 64'(s8), c8, v8, ov8);
            check_rand("n16", 16, 64'(s16), c16, v16, ov16);
            check_rand("n32", 32, 64'(s32), c32, v32, ov32);
            e9     = {1'b0, a_full[7:0]} + {1'b0, b_full[7:0]} + 9'(c_in);
            hold_s = e9[7:0];
            hold_c = e9[8];
            hold_v = (a_full[7] == b_full[7]) && (e9[7] != a_full[7]);
         end else begin
            check_out8("rand_idle", hold_s, hold_c, hold_v, 1'b0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
